// File: rtl/pcie_fifo_pkg.sv
// Shared types and default sizing for the audio PCIe FIFO read-side scheduler.
package pcie_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } sched_state_t;

  localparam int DEF_BURST_LEN   = 16;
  localparam int DEF_TIMEOUT_CYC = 1024;

endpackage

// File: rtl/pcie_fifo_rd_sched_if.sv
// FIFO read port plus DMA request/stream signals seen by the read-side scheduler.
interface pcie_fifo_rd_sched_if #(
  parameter int RD_DEPTH_WIDTH = 13,
  parameter int DATA_WIDTH     = 128
);

  logic                    fifo_rd_en;
  logic [DATA_WIDTH-1:0]   fifo_rd_data;
  logic                    fifo_rd_empty;
  logic [RD_DEPTH_WIDTH:0] fifo_rd_water_level;

  logic                    dma_req;
  logic [RD_DEPTH_WIDTH:0] dma_len;
  logic                    dma_ack;

  // Stream: a beat moves on a cycle where dma_valid && dma_ready; once valid is
  // raised, dma_data/dma_last hold steady until that beat moves.
  logic                    dma_valid;
  logic                    dma_ready;
  logic [DATA_WIDTH-1:0]   dma_data;
  logic                    dma_last;

  modport master (
    output fifo_rd_en,
    input  fifo_rd_data, fifo_rd_empty, fifo_rd_water_level,
    output dma_req, dma_len,
    input  dma_ack,
    output dma_valid, dma_data, dma_last,
    input  dma_ready
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_rd_data, fifo_rd_empty, fifo_rd_water_level,
    input  dma_req, dma_len,
    output dma_ack,
    input  dma_valid, dma_data, dma_last,
    output dma_ready
  );

endinterface

// File: rtl/pcie_skid2.sv
// Two-entry register buffer; entry 0 is always the head presented on dout.
module pcie_skid2 #(
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] mem0;
  logic [DATA_WIDTH-1:0] mem1;
  logic                  do_pop;
  logic                  do_push;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign dout    = mem0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem0  <= '0;
      mem1  <= '0;
      count <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count == 2'd0) mem0 <= din;
          else               mem1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          mem0  <= mem1;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged: the new word lands behind whatever remains.
          if (count == 2'd1) begin
            mem0 <= din;
          end else begin
            mem0 <= mem1;
            mem1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pcie_fifo_rd_sched.sv
// Read-side burst scheduler: watches FIFO water level, requests DMA bursts and streams words out.
module pcie_fifo_rd_sched
  import pcie_fifo_pkg::*;
#(
  parameter int RD_DEPTH_WIDTH = 13,
  parameter int DATA_WIDTH     = 128,
  parameter int BURST_LEN      = DEF_BURST_LEN,
  parameter int TIMEOUT_CYC    = DEF_TIMEOUT_CYC
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 flush,
  pcie_fifo_rd_sched_if.master bus,
  output logic                 busy,
  output logic [15:0]          burst_cnt,
  output sched_state_t         dbg_state,
  output logic [1:0]           dbg_skid_cnt
);

  localparam int            LW = RD_DEPTH_WIDTH + 1;
  localparam logic [LW-1:0] BL = LW'(BURST_LEN);
  localparam logic [31:0]   TO = 32'(TIMEOUT_CYC);

  sched_state_t          state, state_nxt;
  logic [LW-1:0]         len_q, len_nxt;
  logic [LW-1:0]         rd_issued;
  logic [LW-1:0]         beat_cnt;
  logic [LW-1:0]         wl;
  logic [31:0]           idle_cnt;
  logic                  inflight;
  logic                  flush_pend;
  logic                  launch;
  logic                  rd_en;
  logic                  beat;
  logic                  dma_valid_int;
  logic                  last_beat;
  logic [1:0]            skid_cnt;
  logic [1:0]            occ;
  logic [DATA_WIDTH-1:0] skid_dout;

  assign wl  = bus.fifo_rd_water_level;
  assign occ = skid_cnt + {1'b0, inflight};

  // A read is only issued when the skid buffer is guaranteed a slot for its data.
  assign rd_en = (state == XFER) && !bus.fifo_rd_empty && (rd_issued < len_q) && (occ < 2'd2);

  assign dma_valid_int = (skid_cnt != 2'd0);
  assign beat          = dma_valid_int && bus.dma_ready;
  assign last_beat     = (beat_cnt == len_q - LW'(1));

  always_comb begin
    state_nxt = state;
    len_nxt   = len_q;
    launch    = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          if (wl >= BL) begin
            launch  = 1'b1;
            len_nxt = BL;
          end else if ((flush_pend || (idle_cnt == TO)) && (wl != '0)) begin
            launch  = 1'b1;
            len_nxt = wl;
          end
        end
        if (launch) state_nxt = REQ;
      end
      REQ:     if (bus.dma_ack) state_nxt = XFER;
      XFER:    if (beat && last_beat) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      len_q      <= '0;
      rd_issued  <= '0;
      beat_cnt   <= '0;
      inflight   <= 1'b0;
      idle_cnt   <= '0;
      flush_pend <= 1'b0;
      burst_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      len_q    <= len_nxt;
      inflight <= rd_en;

      if (state == REQ) begin
        rd_issued <= '0;
        beat_cnt  <= '0;
      end else begin
        if (rd_en) rd_issued <= rd_issued + LW'(1);
        if (beat)  beat_cnt  <= beat_cnt + LW'(1);
      end

      if ((state == IDLE) && !launch && (wl != '0) && (wl < BL))
        idle_cnt <= (idle_cnt == TO) ? idle_cnt : idle_cnt + 32'd1;
      else
        idle_cnt <= '0;

      // A new pulse wins over a same-cycle clear so a late flush is never dropped.
      if (flush)
        flush_pend <= 1'b1;
      else if ((state == IDLE) && (launch || (wl == '0)))
        flush_pend <= 1'b0;

      if (state == DONE) burst_cnt <= burst_cnt + 16'd1;
    end
  end

  pcie_skid2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight),
    .din   (bus.fifo_rd_data),
    .pop   (beat),
    .dout  (skid_dout),
    .count (skid_cnt)
  );

  assign bus.fifo_rd_en = rd_en;
  assign bus.dma_req    = (state == REQ);
  assign bus.dma_len    = len_q;
  assign bus.dma_valid  = dma_valid_int;
  assign bus.dma_data   = skid_dout;
  assign bus.dma_last   = dma_valid_int && last_beat;

  assign busy         = (state != IDLE);
  assign dbg_state    = state;
  assign dbg_skid_cnt = skid_cnt;

endmodule

// File: tb/tb_pcie_fifo_rd_sched.sv
// Directed bench for pcie_fifo_rd_sched with a behavioural FIFO and an ordered scoreboard.
module tb_pcie_fifo_rd_sched;
  import pcie_fifo_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic         enable;
  logic         flush;
  logic         busy;
  logic [15:0]  burst_cnt;
  sched_state_t dbg_state;
  logic [1:0]   dbg_skid_cnt;

  pcie_fifo_rd_sched_if #(.RD_DEPTH_WIDTH(13), .DATA_WIDTH(128)) bus_if ();

  pcie_fifo_rd_sched #(
    .RD_DEPTH_WIDTH(13),
    .DATA_WIDTH    (128),
    .BURST_LEN     (16),
    .TIMEOUT_CYC   (1024)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .flush        (flush),
    .bus          (bus_if),
    .busy         (busy),
    .burst_cnt    (burst_cnt),
    .dbg_state    (dbg_state),
    .dbg_skid_cnt (dbg_skid_cnt)
  );

  // ---------------- FIFO model ----------------
  int unsigned  push_total = 0;
  int unsigned  pushed = 0;
  int           wl_extra = 0;
  logic [127:0] mq[$];

  function automatic logic [127:0] word_of(input int unsigned n);
    return {n ^ 32'hdead_beef, n, ~n, n + 32'h0000_1000};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      pushed = push_total;
      bus_if.fifo_rd_data        <= '0;
      bus_if.fifo_rd_empty       <= 1'b1;
      bus_if.fifo_rd_water_level <= '0;
    end else begin
      if (bus_if.fifo_rd_en && (mq.size() != 0)) bus_if.fifo_rd_data <= mq.pop_front();
      while (pushed < push_total) begin
        mq.push_back(word_of(pushed));
        pushed++;
      end
      bus_if.fifo_rd_empty       <= (mq.size() == 0);
      bus_if.fifo_rd_water_level <= 14'(mq.size() + wl_extra);
    end
  end

  // ---------------- scoreboard ----------------
  logic [127:0] exp_q[$];
  int           n_vec = 0;
  int           n_err = 0;
  int           bb = 0;
  int           exp_len = 0;
  int           rd_pulses = 0;
  logic         held = 1'b0;
  logic [127:0] held_data = '0;
  logic         rand_ready = 1'b0;
  logic         saw_req;
  int           cyc;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic monitor();
    logic [127:0] w;
    if (bus_if.fifo_rd_en) begin
      rd_pulses++;
      chk("rd_en_while_empty", 128'(bus_if.fifo_rd_empty), 128'(0));
    end
    chk("skid_cnt_le2", 128'(dbg_skid_cnt <= 2'd2), 128'(1));
    if (held && bus_if.dma_valid) chk("data_stable", bus_if.dma_data, held_data);
    if (bus_if.dma_valid && bus_if.dma_ready) begin
      chk("scoreboard_has_word", 128'(exp_q.size() != 0), 128'(1));
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        chk("dma_data_order", bus_if.dma_data, w);
      end
      chk("dma_last", 128'(bus_if.dma_last), 128'(bb + 1 == exp_len));
      bb++;
    end
    held      = bus_if.dma_valid && !bus_if.dma_ready;
    held_data = bus_if.dma_data;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    if (rand_ready) bus_if.dma_ready = ($urandom_range(0, 9) >= 4);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (bus_if.dma_req) saw_req = 1'b1;
    end
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(word_of(push_total));
      push_total++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    wl_extra = 0;
    held = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_req(input int max, output int cycles);
    cycles = 0;
    while (!bus_if.dma_req && (cycles < max)) begin
      tick();
      cycles++;
    end
    chk("req_seen", 128'(bus_if.dma_req), 128'(1));
  endtask

  task automatic ack_burst();
    tick();
    tick();
    chk("req_held", 128'(bus_if.dma_req), 128'(1));
    bus_if.dma_ack = 1'b1;
    exp_len   = int'(bus_if.dma_len);
    bb        = 0;
    rd_pulses = 0;
    tick();
    bus_if.dma_ack = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (busy && (n < max)) begin
      tick();
      n++;
    end
    chk("burst_done", 128'(busy), 128'(0));
  endtask

  task automatic wait_beats(input int k, input int max);
    int n = 0;
    while ((bb < k) && (n < max)) begin
      tick();
      n++;
    end
    chk("beats_reached", 128'(bb >= k), 128'(1));
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_rd_en"},     128'(bus_if.fifo_rd_en), 128'(0));
    chk({tag, "_req"},       128'(bus_if.dma_req),    128'(0));
    chk({tag, "_valid"},     128'(bus_if.dma_valid),  128'(0));
    chk({tag, "_last"},      128'(bus_if.dma_last),   128'(0));
    chk({tag, "_busy"},      128'(busy),              128'(0));
    chk({tag, "_len"},       128'(bus_if.dma_len),    128'(0));
    chk({tag, "_data"},      bus_if.dma_data,         128'(0));
    chk({tag, "_burst_cnt"}, 128'(burst_cnt),         128'(0));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n          = 1'b0;
    enable         = 1'b0;
    flush          = 1'b0;
    bus_if.dma_ack   = 1'b0;
    bus_if.dma_ready = 1'b0;
    tick();
    tick();
    chk_outputs_zero("reset");
    chk("reset_state", 128'(dbg_state), 128'(IDLE));
    rst_n = 1'b1;
    tick();

    // Full bursts from a 40-word FIFO: two of 16, then 8 left waiting.
    bus_if.dma_ready = 1'b1;
    enable = 1'b1;
    push_words(40);
    wait_req(10, cyc);
    chk("full1_len", 128'(bus_if.dma_len), 128'(16));
    ack_burst();
    wait_idle(100);
    chk("full1_beats", 128'(bb), 128'(16));
    wait_req(10, cyc);
    chk("full2_len", 128'(bus_if.dma_len), 128'(16));
    ack_burst();
    wait_idle(100);
    chk("full2_beats", 128'(bb), 128'(16));
    chk("full_burst_cnt", 128'(burst_cnt), 128'(2));
    tick();
    chk("full_wl_left", 128'(bus_if.fifo_rd_water_level), 128'(8));
    saw_req = 1'b0;
    ticks(200);
    chk("full_no_third_req", 128'(saw_req), 128'(0));

    // Timeout: partial burst exactly 1025 cycles after wl becomes 8.
    do_reset();
    push_words(8);
    tick();
    cyc = 0;
    while (!bus_if.dma_req && (cyc < 1100)) begin
      tick();
      cyc++;
    end
    chk("timeout_cycles", 128'(cyc), 128'(1025));
    chk("timeout_len", 128'(bus_if.dma_len), 128'(8));
    ack_burst();
    wait_idle(100);
    chk("timeout_beats", 128'(bb), 128'(8));

    // Flush with 5 words buffered.
    do_reset();
    push_words(5);
    saw_req = 1'b0;
    ticks(4);
    chk("flush_no_early_req", 128'(saw_req), 128'(0));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_req(5, cyc);
    chk("flush_req_latency", 128'(cyc), 128'(1));
    chk("flush_len", 128'(bus_if.dma_len), 128'(5));
    ack_burst();
    wait_idle(100);
    chk("flush_beats", 128'(bb), 128'(5));

    // Flush with nothing buffered must not linger as a pending flush.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    saw_req = 1'b0;
    ticks(10);
    chk("flush_empty_no_req", 128'(saw_req), 128'(0));
    push_words(3);
    ticks(20);
    chk("flush_pend_cleared", 128'(saw_req), 128'(0));

    // Backpressure: random ready during a 16-word burst.
    do_reset();
    rand_ready = 1'b1;
    push_words(16);
    wait_req(10, cyc);
    chk("bp_len", 128'(bus_if.dma_len), 128'(16));
    ack_burst();
    wait_idle(400);
    chk("bp_beats", 128'(bb), 128'(16));
    chk("bp_rd_pulses", 128'(rd_pulses), 128'(16));
    rand_ready = 1'b0;
    bus_if.dma_ready = 1'b1;

    // Underflow: level reports 16 while only 10 words are readable.
    do_reset();
    wl_extra = 6;
    push_words(10);
    wait_req(10, cyc);
    chk("uf_len", 128'(bus_if.dma_len), 128'(16));
    ack_burst();
    ticks(60);
    chk("uf_stalled_beats", 128'(bb), 128'(10));
    chk("uf_still_busy", 128'(busy), 128'(1));
    wl_extra = 0;
    push_words(6);
    wait_idle(100);
    chk("uf_beats", 128'(bb), 128'(16));
    chk("uf_burst_cnt", 128'(burst_cnt), 128'(1));

    // Enable dropped mid-burst, then reset mid-burst.
    do_reset();
    push_words(32);
    wait_req(10, cyc);
    ack_burst();
    wait_beats(4, 100);
    enable = 1'b0;
    wait_idle(100);
    chk("en_beats", 128'(bb), 128'(16));
    chk("en_burst_cnt", 128'(burst_cnt), 128'(1));
    saw_req = 1'b0;
    ticks(50);
    chk("en_stays_idle", 128'(saw_req), 128'(0));
    enable = 1'b1;
    wait_req(10, cyc);
    ack_burst();
    wait_beats(7, 100);
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("midreset");
    exp_q.delete();
    held = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pcie_fifo_rd_sched.md
# pcie_fifo_rd_sched

Read-side scheduler for the 16-to-128-bit audio PCIe FIFO, running in the FIFO read-clock domain. It watches the FIFO read water level and sequences fixed-length DMA bursts of 128-bit words toward the PCIe DMA engine. It issues a shorter partial burst when data has sat below burst size for too long, or when software requests a flush. It owns the FIFO `rd_en` and absorbs downstream backpressure with a 2-entry skid buffer.

## Interface
- `RD_DEPTH_WIDTH`, 13: FIFO read address width; water level is `RD_DEPTH_WIDTH+1` bits.
- `DATA_WIDTH`, 128: FIFO read / DMA data width.
- `BURST_LEN`, 16: full burst length in words; 1..2^RD_DEPTH_WIDTH.
- `TIMEOUT_CYC`, 1024: idle cycles before a partial burst is forced; ≥1.
- `clk` in 1: FIFO read clock.
- `rst_n` in 1: **asynchronous, active-low reset.**
- `enable` in 1: level; allows new bursts to start.
- `flush` in 1: single-cycle pulse; forces a partial burst of whatever is buffered.
- `fifo_rd_en` out 1: FIFO read enable.
- `fifo_rd_data` in DATA_WIDTH: FIFO read data, valid 1 cycle after `fifo_rd_en`.
- `fifo_rd_empty` in 1: FIFO empty.
- `fifo_rd_water_level` in RD_DEPTH_WIDTH+1: FIFO read-side occupancy.
- `dma_req` out 1: burst request; held until acked.
- `dma_len` out RD_DEPTH_WIDTH+1: burst word count; stable while `dma_req` is high.
- `dma_ack` in 1: single-cycle grant.
- `dma_valid` out 1, `dma_ready` in 1, `dma_data` out DATA_WIDTH, `dma_last` out 1: valid/ready stream.
- `busy` out 1: state ≠ IDLE.
- `burst_cnt` out 16: completed bursts; wraps at 0xFFFF→0.

## Operation
- States: IDLE, REQ, XFER, DONE.
- **IDLE** `idle_cnt`:
  - Increments while `0 < wl < BURST_LEN`.
  - Clears when `wl == 0`, `wl ≥ BURST_LEN`, or on leaving IDLE.
  - Saturates at TIMEOUT_CYC.
- **IDLE→REQ** requires `enable`, then takes the first matching condition:
  - `wl ≥ BURST_LEN`: `len = BURST_LEN`.
  - else `flush_pend` or `idle_cnt == TIMEOUT_CYC`, with `wl > 0`: `len = wl`.
  - `len` is latched into `dma_len`.
- `flush_pend`:
  - Sets on a `flush` pulse in any state.
  - Clears when a burst is launched from IDLE.
  - Also clears if `wl == 0` while in IDLE, i.e. nothing to flush.
- **REQ**: `dma_req=1`. On `dma_ack`, go to XFER; `dma_req` drops the same edge.
- **XFER**:
  - `fifo_rd_en = !fifo_rd_empty && (rd_issued < len) && (skid_cnt + inflight < 2)`.
  - `inflight` is a 1-bit flag set on the cycle after `rd_en`; that data is written into the skid buffer.
  - The skid head drives `dma_data`; `dma_valid = (skid_cnt != 0)`.
  - A beat transfers on `dma_valid && dma_ready`; `beat_cnt` increments.
  - `dma_last = dma_valid && (beat_cnt == len-1)`.
  - After the last beat transfers, go to DONE.
- **DONE**: 1 cycle; `burst_cnt++`; go to IDLE.
- Deasserting `enable` mid-burst does not abort; the current burst completes.
- `dma_ready` low: data is held stable; the skid buffer fills to 2, then `rd_en` stalls. No word is lost or duplicated.
- Simultaneous skid push and pop keeps occupancy unchanged.
- Reset mid-burst: everything returns to reset values immediately. Words already popped are lost; the FIFO is reset alongside by the system.
- `len` width is RD_DEPTH_WIDTH+1; counters are the same width; no overflow possible.

## Timing
- Reset values:
  - `fifo_rd_en`, `dma_req`, `dma_valid`, `dma_last`, `busy` = 0.
  - `dma_len`, `dma_data`, `burst_cnt` = 0.
  - State = IDLE.
- `fifo_rd_en` is combinational from registered state/counters and `fifo_rd_empty`. All other outputs are registered or derived from registered skid state.
- IDLE→REQ: 1 cycle after the condition is sampled.
- `dma_ack`→first `fifo_rd_en`: 1 cycle (XFER entry).
- First `dma_valid`: 2 cycles after the first `rd_en`, covering FIFO latency plus the skid write.
- With `dma_ready` held high and the FIFO non-empty, throughput is 1 word/cycle after the initial latency.
- `dma_ack` outside REQ is ignored.

## Structure
- Package `pcie_fifo_pkg`: state enum (IDLE, REQ, XFER, DONE) and default BURST_LEN/TIMEOUT_CYC constants.
- One sub-module, `pcie_skid2`: 2-entry DATA_WIDTH register buffer.
  - Ports: push, din, pop, dout, count.
  - Reset count=0.
- Scheduler FSM and counters live in the top module.

## Test plan
- **Full burst:** after reset, preload the FIFO with 40 words (wl=40), `enable=1`, `dma_ack` 3 cycles after `dma_req`, `dma_ready=1`.
  - Expect `dma_len=16` and 16 beats in order with `dma_last` on beat 16.
  - Then a second burst of 16; `burst_cnt=2`; wl ends at 8; no third request until timeout.
- **Timeout:** wl=8, TIMEOUT_CYC=1024.
  - Expect `dma_req` with `dma_len=8` exactly 1025 cycles after wl becomes 8.
- **Flush:** wl=5, `flush` pulse → `dma_len=5` and 5 beats.
  - A flush with wl=0 → no request, and `flush_pend` cleared.
- **Backpressure:** burst of 16 with `dma_ready` toggling at random (≥30% low).
  - Expect the `dma_data` sequence to equal the FIFO order.
  - `dma_data` stays stable while valid and not ready.
  - Exactly 16 `fifo_rd_en` pulses.
  - `skid_cnt` never exceeds 2.
- **Underflow mid-burst:** `dma_len=16` with only 10 words present; the remaining 6 are written later.
  - `fifo_rd_en` never asserts while empty.
  - The burst completes once data arrives.
- **Enable/reset:** `enable` drops at beat 4 → the burst still completes, then stays IDLE.
  - `rst_n` low at beat 7 of the next burst → all outputs 0 within the same cycle.
